pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 4-buffer pipeline (FD, DE, EM, MW).
- Drives the wrt_en and noop inputs of every pipeline buffer, plus the PC write enable.
- Resolves three events: load-use hazards with a configurable load latency, multi-cycle data-memory waits in M, and control redirects resolved in E.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the FD/DE/EM/MW pipeline: load-use interlock,
// data-memory wait freeze and E-stage redirect squash, plus a stall counter.
module pipe_hazard_ctrl #(
  parameter int REGNO    = 4,
  parameter int LOAD_LAT = 2,
  parameter int CNTW     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REGNO-1:0] src1Index_D,
  input  logic [REGNO-1:0] src2Index_D,
  input  logic             src1Used_D,
  input  logic             src2Used_D,
  input  logic [REGNO-1:0] destIndex_E,
  input  logic             regWrtEn_E,
  input  logic [1:0]       regFileMux_E,
  input  logic             noop_E,
  input  logic             redirect_E,
  input  logic             memBusy_M,
  output logic             pcWrtEn,
  output logic             fdWrtEn,
  output logic             deWrtEn,
  output logic             emWrtEn,
  output logic             mwWrtEn,
  output logic             fdNoop,
  output logic             deNoop,
  output logic             mwNoop,
  output logic [CNTW-1:0]  stallCycles
);

  typedef enum logic [1:0] {RUN, LSTALL, MWAIT} state_t;

  // Output pattern chosen this cycle; decoded into the enable/bubble pins below.
  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_BUSY,
    ACT_REDIR,
    ACT_LOADSTALL,
    ACT_NORMAL
  } action_t;

  // Cycles spent in LSTALL after the first interlock cycle is LOAD_LAT-1.
  localparam logic [1:0] LCNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  state_t     state, state_n;
  state_t     ret_state, ret_state_n;
  state_t     eff_state;
  logic [1:0] lcnt, lcnt_n;
  action_t    action;
  logic       redir;
  logic       load_use;
  logic       src1_hit;
  logic       src2_hit;

  assign redir    = redirect_E & ~noop_E;
  assign src1_hit = src1Used_D & (src1Index_D == destIndex_E);
  assign src2_hit = src2Used_D & (src2Index_D == destIndex_E);
  assign load_use = regWrtEn_E & ~noop_E & (regFileMux_E == 2'b01) & (src1_hit | src2_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
      lcnt      <= 2'd0;
    end else begin
      state     <= state_n;
      ret_state <= ret_state_n;
      lcnt      <= lcnt_n;
    end
  end

  // On release from MWAIT the controller behaves exactly as the state it left.
  always_comb begin
    state_n     = state;
    ret_state_n = ret_state;
    lcnt_n      = lcnt;
    action      = ACT_NORMAL;
    eff_state   = (state == MWAIT) ? ret_state : state;

    if (reset) begin
      action  = ACT_RESET;
      state_n = RUN;
    end else if (memBusy_M) begin
      action      = ACT_BUSY;
      state_n     = MWAIT;
      ret_state_n = eff_state;
    end else if (eff_state == LSTALL) begin
      action = ACT_LOADSTALL;
      if (lcnt == 2'd0) begin
        state_n = RUN;
      end else begin
        state_n = LSTALL;
        lcnt_n  = lcnt - 2'd1;
      end
    end else if (redir) begin
      action  = ACT_REDIR;
      state_n = RUN;
    end else if (load_use) begin
      action = ACT_LOADSTALL;
      if (LOAD_LAT > 1) begin
        state_n = LSTALL;
        lcnt_n  = LCNT_INIT;
      end else begin
        state_n = RUN;
      end
    end else begin
      action  = ACT_NORMAL;
      state_n = RUN;
    end
  end

  always_comb begin
    pcWrtEn = 1'b1;
    fdWrtEn = 1'b1;
    deWrtEn = 1'b1;
    emWrtEn = 1'b1;
    mwWrtEn = 1'b1;
    fdNoop  = 1'b0;
    deNoop  = 1'b0;
    mwNoop  = 1'b0;
    case (action)
      ACT_RESET: begin
        pcWrtEn = 1'b0;
        fdWrtEn = 1'b0;
        deWrtEn = 1'b0;
        emWrtEn = 1'b0;
        mwWrtEn = 1'b0;
        fdNoop  = 1'b1;
        deNoop  = 1'b1;
        mwNoop  = 1'b1;
      end
      ACT_BUSY: begin
        pcWrtEn = 1'b0;
        fdWrtEn = 1'b0;
        deWrtEn = 1'b0;
        emWrtEn = 1'b0;
        fdNoop  = 1'b1;
        deNoop  = 1'b1;
        mwNoop  = 1'b1;
      end
      ACT_REDIR: begin
        fdNoop = 1'b1;
        deNoop = 1'b1;
      end
      ACT_LOADSTALL: begin
        pcWrtEn = 1'b0;
        fdWrtEn = 1'b0;
        deNoop  = 1'b1;
      end
      default: begin
        pcWrtEn = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (!pcWrtEn && (stallCycles != {CNTW{1'b1}})) begin
      stallCycles <= stallCycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl; three builds (LOAD_LAT 2/1/3,
// one with a 4-bit counter) share stimulus and are checked against a cycle model.
module tb_pipe_hazard_ctrl;
  localparam int REGNO = 4;
  localparam int NI    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [REGNO-1:0] src1Index_D, src2Index_D, destIndex_E;
  logic             src1Used_D, src2Used_D, regWrtEn_E, noop_E, redirect_E, memBusy_M;
  logic [1:0]       regFileMux_E;

  logic [4:0]  enV   [NI];
  logic [2:0]  noopV [NI];
  logic [31:0] scV   [NI];

  int     checks = 0;
  int     errors = 0;
  int     lat    [NI] = '{2, 1, 3};
  longint satMax [NI] = '{65535, 65535, 15};
  int     stallLeft [NI];
  longint cnt       [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LL = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    localparam int CW = (g == 2) ? 4 : 16;
    logic pcW, fdW, deW, emW, mwW, fdN, deN, mwN;
    logic [CW-1:0] sc;
    pipe_hazard_ctrl #(.REGNO(REGNO), .LOAD_LAT(LL), .CNTW(CW)) dut (
      .clk(clk), .reset(reset),
      .src1Index_D(src1Index_D), .src2Index_D(src2Index_D),
      .src1Used_D(src1Used_D), .src2Used_D(src2Used_D),
      .destIndex_E(destIndex_E), .regWrtEn_E(regWrtEn_E),
      .regFileMux_E(regFileMux_E), .noop_E(noop_E),
      .redirect_E(redirect_E), .memBusy_M(memBusy_M),
      .pcWrtEn(pcW), .fdWrtEn(fdW), .deWrtEn(deW), .emWrtEn(emW), .mwWrtEn(mwW),
      .fdNoop(fdN), .deNoop(deN), .mwNoop(mwN), .stallCycles(sc)
    );
    assign enV[g]   = {pcW, fdW, deW, emW, mwW};
    assign noopV[g] = {fdN, deN, mwN};
    assign scV[g]   = 32'(sc);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Model: stallLeft counts remaining forced interlock cycles; a memory wait freezes it.
  task automatic runCycle();
    logic       lu, rd;
    logic [4:0] expEn;
    logic [2:0] expNoop, mask;
    @(negedge clk);
    rd = redirect_E && !noop_E;
    lu = regWrtEn_E && !noop_E && (regFileMux_E == 2'b01) &&
         ((src1Used_D && src1Index_D == destIndex_E) || (src2Used_D && src2Index_D == destIndex_E));
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        expEn = 5'b00000; expNoop = 3'b111; mask = 3'b111;
      end else if (memBusy_M) begin
        expEn = 5'b00001; expNoop = 3'b001; mask = 3'b001;
      end else if (stallLeft[i] > 0) begin
        expEn = 5'b00111; expNoop = 3'b010; mask = 3'b011;
        stallLeft[i] = stallLeft[i] - 1;
      end else if (rd) begin
        expEn = 5'b11111; expNoop = 3'b110; mask = 3'b111;
      end else if (lu) begin
        expEn = 5'b00111; expNoop = 3'b010; mask = 3'b011;
        stallLeft[i] = lat[i] - 1;
      end else begin
        expEn = 5'b11111; expNoop = 3'b000; mask = 3'b111;
      end
      checkOutput($sformatf("en%0d", i), 32'(enV[i]), 32'(expEn));
      checkOutput($sformatf("noop%0d", i), 32'(noopV[i] & mask), 32'(expNoop & mask));
      checkOutput($sformatf("stallCycles%0d", i), scV[i], 32'(cnt[i]));
      if (reset) begin
        cnt[i] = 0;
        stallLeft[i] = 0;
      end else if (!expEn[4] && cnt[i] < satMax[i]) begin
        cnt[i] = cnt[i] + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Directed cycle: loadHit places a load to r3 in E with D reading r3 via src2.
  task automatic applyStimulus(input logic rst, input logic busy, input logic redir,
                               input logic nE, input logic loadHit);
    reset        = rst;
    memBusy_M    = busy;
    redirect_E   = redir;
    noop_E       = nE;
    regWrtEn_E   = 1'b1;
    regFileMux_E = 2'b01;
    destIndex_E  = 4'd3;
    src1Used_D   = 1'b1;
    src1Index_D  = 4'd7;
    src2Used_D   = loadHit;
    src2Index_D  = 4'd3;
    runCycle();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      stallLeft[i] = 0;
      cnt[i] = 0;
    end
    reset = 1'b1; memBusy_M = 1'b0; redirect_E = 1'b0; noop_E = 1'b1;
    regWrtEn_E = 1'b0; regFileMux_E = 2'b00; destIndex_E = '0;
    src1Index_D = '0; src2Index_D = '0; src1Used_D = 1'b0; src2Used_D = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] load-use latency");
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lat2_total", scV[0], 32'd2);
    checkOutput("lat1_total", scV[1], 32'd1);
    checkOutput("lat3_total", scV[2], 32'd3);

    $display("[TB] redirect vs load-use");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("redir_nostall", scV[0], 32'd0);

    $display("[TB] memory wait inside load stall");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mwait_total", scV[0], 32'd5);

    $display("[TB] reset during memory wait");
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post_reset_count", scV[0], 32'd0);

    $display("[TB] counter saturation");
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 19; k++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("sat4", scV[2], 32'd15);
    checkOutput("nosat16", scV[0], 32'd19);

    $display("[TB] random traffic");
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      reset        = ($urandom_range(0, 49) == 0);
      memBusy_M    = ($urandom_range(0, 4) == 0);
      redirect_E   = ($urandom_range(0, 7) == 0);
      noop_E       = ($urandom_range(0, 3) == 0);
      regWrtEn_E   = ($urandom_range(0, 3) != 0);
      regFileMux_E = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      destIndex_E  = 4'($urandom_range(0, 3));
      src1Index_D  = 4'($urandom_range(0, 3));
      src2Index_D  = 4'($urandom_range(0, 3));
      src1Used_D   = 1'($urandom_range(0, 1));
      src2Used_D   = 1'($urandom_range(0, 1));
      runCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
